// File: rtl/cp0_ctrl_pkg.sv
// cp0_ctrl_pkg: shared CP0 definitions.
// Holds the exception codes, CP0 register numbers, the handler entry point,
// the state encoding and the EPC computation helper.
package cp0_ctrl_pkg;

    // Exception codes written into Cause.ExcCode
    localparam logic [4:0] EXC_INT   = 5'd0;
    localparam logic [4:0] EXC_ADEL  = 5'd4;
    localparam logic [4:0] EXC_ADES  = 5'd5;
    localparam logic [4:0] EXC_RI    = 5'd10;
    localparam logic [4:0] EXC_OV    = 5'd12;

    // CP0 register numbers as seen by mtc0/mfc0
    localparam logic [4:0] ADDR_SR    = 5'd12;
    localparam logic [4:0] ADDR_CAUSE = 5'd13;
    localparam logic [4:0] ADDR_EPC   = 5'd14;
    localparam logic [4:0] ADDR_PRID  = 5'd15;

    // Fixed exception vector and processor identification word
    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
    localparam logic [31:0] PRID_VALUE = 32'h2023_0007;

    // The state is exactly the SR.EXL bit
    typedef enum logic {
        ST_NORMAL  = 1'b0,
        ST_HANDLER = 1'b1
    } cp0_state_e;

    // Restart address: a delay-slot instruction restarts at its branch.
    // Subtraction wraps modulo 2^32; the result is always word aligned.
    function automatic logic [31:0] epc_target(input logic [31:0] pc, input logic is_bd);
        logic [31:0] raw;
        raw = is_bd ? (pc - 32'd4) : pc;
        return {raw[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/cp0_ctrl_if.sv
// cp0_ctrl_if: pipeline / mtc0 / mfc0 signal bundle between the core and CP0.
// The core side uses the master modport, CP0 itself the slave modport.
interface cp0_ctrl_if;
    logic [4:0]  M_exCode;
    logic [31:0] M_pc;
    logic        M_isBD;
    logic [5:0]  HWInt;
    logic        cp0_we;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic        eret;
    logic [31:0] cp0_rdata;
    logic        req;
    logic [31:0] EPC_out;
    logic [31:0] handler_pc;

    modport master (
        output M_exCode, M_pc, M_isBD, HWInt, cp0_we, cp0_addr, cp0_wdata, eret,
        input  cp0_rdata, req, EPC_out, handler_pc
    );

    modport slave (
        input  M_exCode, M_pc, M_isBD, HWInt, cp0_we, cp0_addr, cp0_wdata, eret,
        output cp0_rdata, req, EPC_out, handler_pc
    );
endinterface

// File: rtl/cp0_req_gen.sv
// cp0_req_gen: combinational exception/interrupt request and ExcCode select.
// Interrupts beat synchronous exceptions; everything is masked while EXL=1.
module cp0_req_gen
    import cp0_ctrl_pkg::*;
(
    input  logic [4:0] ex_code,
    input  logic [5:0] hw_int,
    input  logic [5:0] im,
    input  logic       ie,
    input  logic       exl,
    output logic       req,
    output logic [4:0] exc_code_sel
);

    logic int_req;
    logic exc_req;

    // Request qualification and priority-ordered cause selection
    always_comb begin
        int_req      = (|(hw_int & im)) & ie & ~exl;
        exc_req      = (ex_code != 5'd0) & ~exl;
        req          = int_req | exc_req;
        exc_code_sel = int_req ? EXC_INT : ex_code;
    end

endmodule

// File: rtl/cp0_ctrl.sv
// cp0_ctrl: CP0 register file (SR, Cause, EPC) with exception entry / eret.
// Optional feature: define CP0_PRID_EN to expose a read-only PRId at address 15.
module cp0_ctrl
    import cp0_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    cp0_ctrl_if.slave  bus
);

    // SR state: EXL lives in state_q
    cp0_state_e  state_q, state_d;
    logic [5:0]  im_q, im_d;
    logic        ie_q, ie_d;
    // Cause state
    logic        bd_q, bd_d;
    logic [5:0]  ip_q, ip_d;
    logic [4:0]  exc_code_q, exc_code_d;
    // EPC state
    logic [31:0] epc_q, epc_d;

    logic        exl;
    logic        req_raw;
    logic [4:0]  exc_code_sel;
    logic [31:0] sr_word;
    logic [31:0] cause_word;

    // SR bits [9:2] and [31:16] do not exist, so those write-data bits are dropped
    logic        unused_wdata;
    assign unused_wdata = ^{bus.cp0_wdata[31:16], bus.cp0_wdata[9:2]};

    assign exl = (state_q == ST_HANDLER);

    cp0_req_gen u_req_gen (
        .ex_code      (bus.M_exCode),
        .hw_int       (bus.HWInt),
        .im           (im_q),
        .ie           (ie_q),
        .exl          (exl),
        .req          (req_raw),
        .exc_code_sel (exc_code_sel)
    );

    // Next-state: exception entry beats mtc0 and eret; otherwise mtc0 then eret
    always_comb begin
        state_d    = state_q;
        im_d       = im_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        ip_d       = bus.HWInt;
        exc_code_d = exc_code_q;
        epc_d      = epc_q;

        if (req_raw) begin
            state_d    = ST_HANDLER;
            bd_d       = bus.M_isBD;
            exc_code_d = exc_code_sel;
            epc_d      = epc_target(bus.M_pc, bus.M_isBD);
        end else begin
            if (bus.cp0_we) begin
                case (bus.cp0_addr)
                    ADDR_SR: begin
                        im_d    = bus.cp0_wdata[15:10];
                        ie_d    = bus.cp0_wdata[0];
                        state_d = cp0_state_e'(bus.cp0_wdata[1]);
                    end
                    ADDR_EPC: epc_d = bus.cp0_wdata;
                    default: ;
                endcase
            end
            if (bus.eret) begin
                state_d = ST_NORMAL;
            end
        end
    end

    // Register update with synchronous active-low clear
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_NORMAL;
            im_q       <= '0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ip_q       <= '0;
            exc_code_q <= '0;
            epc_q      <= '0;
        end else begin
            state_q    <= state_d;
            im_q       <= im_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            ip_q       <= ip_d;
            exc_code_q <= exc_code_d;
            epc_q      <= epc_d;
        end
    end

    // Architectural register images and mfc0 read mux (reads pre-edge values)
    always_comb begin
        sr_word    = {16'd0, im_q, 8'd0, exl, ie_q};
        cause_word = {bd_q, 15'd0, ip_q, 3'd0, exc_code_q, 2'd0};
        case (bus.cp0_addr)
            ADDR_SR:    bus.cp0_rdata = sr_word;
            ADDR_CAUSE: bus.cp0_rdata = cause_word;
            ADDR_EPC:   bus.cp0_rdata = epc_q;
`ifdef CP0_PRID_EN
            ADDR_PRID:  bus.cp0_rdata = PRID_VALUE;
`endif
            default:    bus.cp0_rdata = 32'd0;
        endcase
    end

    // Outputs: request is suppressed while reset is asserted
    always_comb begin
        bus.req        = req_raw & reset_n;
        bus.EPC_out    = epc_q;
        bus.handler_pc = HANDLER_PC;
    end

endmodule

// File: doc/cp0_ctrl.md
CP0_CTRL -- requirements
Module: cp0_ctrl

Interface
REQ-001 SHALL have clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have reset_n, input, 1, synchronous active-low reset, sampled on rising clk.
REQ-003 SHALL have M_exCode, input, 5, exception code from the pipeline for the M-stage instruction; 0 means none.
REQ-004 SHALL have M_pc, input, 32, PC of the M-stage instruction.
REQ-005 SHALL have M_isBD, input, 1, M-stage instruction is in a branch delay slot.
REQ-006 SHALL have HWInt, input, 6, level-sensitive hardware interrupt lines.
REQ-007 SHALL have cp0_we, cp0_addr (5), cp0_wdata (32), inputs, mtc0 write port.
REQ-008 SHALL have eret, input, 1, M-stage instruction is eret.
REQ-009 SHALL have cp0_rdata, output, 32, combinational mfc0 read of cp0_addr.
REQ-010 SHALL have req, output, 1, take exception or interrupt this cycle and flush the pipeline.
REQ-011 SHALL have EPC_out, output, 32, current EPC register value, the eret target.
REQ-012 SHALL have handler_pc, output, 32, constant 32'h0000_4180.

Function
REQ-013 SHALL hold SR (addr 12), Cause (13) and EPC (14); all other addresses read 0 and ignore writes.
REQ-014 SR fields SHALL be IM[15:10], EXL[1] and IE[0]; other bits read 0.
REQ-015 Cause fields SHALL be BD[31], IP[15:10] and ExcCode[6:2]; other bits read 0.
REQ-016 SHALL implement two states: NORMAL (EXL=0) and HANDLER (EXL=1).
REQ-017 int_req SHALL equal |(HWInt & IM) & IE & !EXL.
REQ-018 exc_req SHALL equal (M_exCode != 0) & !EXL.
REQ-019 req SHALL be combinational and equal int_req | exc_req.
REQ-020 An interrupt SHALL take priority over an exception.
REQ-021 On a req edge, the block SHALL set EXL=1 and set Cause.BD=M_isBD.
REQ-022 On a req edge, Cause.ExcCode SHALL take 0 for an interrupt, otherwise M_exCode.
REQ-023 On a req edge, EPC SHALL take (M_isBD ? M_pc-4 : M_pc) with bits [1:0] forced to 0.
REQ-024 Cause.IP SHALL load HWInt on every edge, regardless of state.
REQ-025 eret without req SHALL clear EXL on the next edge (HANDLER -> NORMAL); eret with req SHALL be ignored.
REQ-026 An mtc0 write SHALL take effect on the next edge; cp0_rdata in the same cycle SHALL return the old value.
REQ-027 When req and cp0_we occur together, the exception updates SHALL win and the mtc0 write SHALL be dropped entirely.
REQ-028 mtc0 to Cause SHALL be ignored; Cause is read-only to software.
REQ-029 In HANDLER, further exceptions and interrupts SHALL be masked (req=0) until eret.
REQ-030 Arithmetic SHALL be 32-bit with wraparound; M_pc=0 in a delay slot gives EPC=32'hFFFF_FFFC.

Reset
REQ-031 While reset_n=0 at an edge, SR, Cause and EPC SHALL clear to 0, giving state NORMAL.
REQ-032 req SHALL be forced to 0 while reset_n=0.
REQ-033 Reset SHALL override any req, eret or mtc0 in the same cycle.
REQ-034 After reset, EPC_out SHALL be 0 and cp0_rdata SHALL reflect the cleared registers.

Configuration
REQ-035 With CP0_PRID_EN defined, address 15 SHALL read constant 32'h2023_0007 (PRId), read-only.
REQ-036 Without CP0_PRID_EN, address 15 SHALL read 0 and no PRId logic SHALL exist.

Structure
REQ-037 ExcCode constants (Int=0, L_adEx=4, S_adEx=5, RI=10, Ov=12), register addresses and handler_pc SHALL live in shared header cpuex_def_h.v.
REQ-038 The req/priority/ExcCode selection SHALL be one combinational sub-module, cp0_req_gen.
REQ-039 The register file and mtc0/mfc0 logic SHALL stay in cp0_ctrl.

Verification
REQ-040 Bench SHALL check: reset, then M_exCode=12 (Ov) with M_pc=32'h3008 and M_isBD=0 -> req=1 that cycle; next edge EPC=32'h3008, Cause.ExcCode=12, EXL=1.
REQ-041 Bench SHALL check: SR=32'h0000_0401 via mtc0, then HWInt=6'b000001 -> req=1; next edge ExcCode=0 and Cause.IP[10]=1.
REQ-042 Bench SHALL check: M_isBD=1, M_pc=32'h3010, M_exCode=4 -> EPC=32'h300C and Cause.BD=1.
REQ-043 Bench SHALL check: in HANDLER, M_exCode=5 -> req=0; then eret -> EXL=0 next edge; a repeated M_exCode=5 -> req=1.
REQ-044 Bench SHALL check: req with simultaneous mtc0 EPC=32'hDEAD_BEEF -> EPC holds the exception PC and the write is dropped.
REQ-045 Bench SHALL check: reset_n=0 while EXL=1 -> next edge all registers 0; with CP0_PRID_EN, a read of address 15 returns 32'h2023_0007.
